// File: rtl/rps_pkg.sv
// Shared codes for the stone-paper-scissors datapath.
// Winner codes come from the round evaluator; match-state codes are
// what the scorer reports to the status mux. Both sides import this.
package rps_pkg;

  typedef enum logic [1:0] {
    WIN_TIE     = 2'b00,
    WIN_P1      = 2'b01,
    WIN_P2      = 2'b10,
    WIN_INVALID = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    MS_PLAY = 2'b00,
    MS_P1   = 2'b01,
    MS_P2   = 2'b10,
    MS_DRAW = 2'b11
  } match_state_e;

  localparam int WIN_TARGET_DEF = 3;
  localparam int MAX_ROUNDS_DEF = 9;
  localparam int SCORE_W_DEF    = 3;
  localparam int ROUND_W_DEF    = 4;

  // 2-bit increment that sticks at 3
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/rps_match_scorer_if.sv
// Round-result / scoreboard bundle between the evaluator side (master)
// and the match scorer (slave).
//   res_valid, res_winner, new_match : master -> scorer
//   p1_score, p2_score, round_cnt, invalid_cnt, last_result,
//   match_state, match_done           : scorer -> master
interface rps_match_scorer_if #(
  parameter int SCORE_W = 3,
  parameter int ROUND_W = 4
);
  logic               res_valid;
  logic [1:0]         res_winner;
  logic               new_match;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [ROUND_W-1:0] round_cnt;
  logic [1:0]         invalid_cnt;
  logic [1:0]         last_result;
  logic [1:0]         match_state;
  logic               match_done;

  modport master (
    output res_valid, res_winner, new_match,
    input  p1_score, p2_score, round_cnt, invalid_cnt, last_result,
           match_state, match_done
  );

  modport slave (
    input  res_valid, res_winner, new_match,
    output p1_score, p2_score, round_cnt, invalid_cnt, last_result,
           match_state, match_done
  );
endinterface

// File: rtl/rps_rise_detect.sv
// Registered level-to-pulse converter.
//   lvl  : level input
//   ena  : when low the history flop holds and no pulse is produced
//   rise : combinational, high in the cycle where lvl is high and the
//          previously sampled (enabled) level was low
module rps_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic lvl,
  output logic rise
);
  logic lvl_d, lvl_q;

  always_comb begin
    lvl_d = ena ? lvl : lvl_q;
    rise  = lvl & ~lvl_q & ena;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl_d;
  end
endmodule

// File: rtl/rps_match_scorer.sv
// Best-of-N match scorer fed by the round evaluator.
//   clk, rst_n : clock, async active-low reset
//   ena        : global enable, all state holds while low
//   sif        : slave side of rps_match_scorer_if (round result in,
//                scores / counts / match outcome out)
// One round is taken per rising edge of res_valid. Scores and the match
// state update on that same edge; the outcome latches until new_match.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = WIN_TARGET_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int ROUND_W    = ROUND_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  rps_match_scorer_if.slave   sif
);
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [ROUND_W-1:0] RLIMIT = ROUND_W'(MAX_ROUNDS);

  logic rise, clr, accept;

  logic [SCORE_W-1:0] p1_d, p1_q, p2_d, p2_q;
  logic [ROUND_W-1:0] round_d, round_q;
  logic [1:0]         inv_d, inv_q;
  logic [1:0]         last_d, last_q;
  match_state_e       state_d, state_q;

  rps_rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .lvl  (sif.res_valid),
    .rise (rise)
  );

  // Clear wins over a coincident round; rounds after the outcome are dropped.
  always_comb begin
    clr    = ena & sif.new_match;
    accept = rise & ~clr & (state_q == MS_PLAY);
  end

  // Score / count datapath
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    round_d = round_q;
    inv_d   = inv_q;
    last_d  = last_q;
    if (clr) begin
      p1_d    = '0;
      p2_d    = '0;
      round_d = '0;
      inv_d   = '0;
      last_d  = '0;
    end else if (accept) begin
      last_d = sif.res_winner;
      case (sif.res_winner)
        WIN_P1: begin
          p1_d    = p1_q + 1'b1;
          round_d = round_q + 1'b1;
        end
        WIN_P2: begin
          p2_d    = p2_q + 1'b1;
          round_d = round_q + 1'b1;
        end
        WIN_TIE:  round_d = round_q + 1'b1;
        default:  inv_d   = sat_inc2(inv_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q    <= '0;
      p2_q    <= '0;
      round_q <= '0;
      inv_q   <= '0;
      last_q  <= '0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      round_q <= round_d;
      inv_q   <= inv_d;
      last_q  <= last_d;
    end
  end

  // Match FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MS_PLAY;
    else        state_q <= state_d;
  end

  // Match FSM: next state, judged on the post-update counts
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = MS_PLAY;
    end else if (accept) begin
      if (p1_d == TARGET)        state_d = MS_P1;
      else if (p2_d == TARGET)   state_d = MS_P2;
      else if (round_d == RLIMIT) begin
        if (p1_d > p2_d)         state_d = MS_P1;
        else if (p2_d > p1_d)    state_d = MS_P2;
        else                     state_d = MS_DRAW;
      end
    end
  end

  // Match FSM: outputs
  always_comb begin
    sif.p1_score    = p1_q;
    sif.p2_score    = p2_q;
    sif.round_cnt   = round_q;
    sif.invalid_cnt = inv_q;
    sif.last_result = last_q;
    sif.match_state = state_q;
    sif.match_done  = (state_q != MS_PLAY);
  end
endmodule

// File: tb/tb_rps_match_scorer.sv
module tb_rps_match_scorer;
  localparam int WIN_TARGET = 3;
  localparam int MAX_ROUNDS = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  rps_match_scorer_if #(.SCORE_W(3), .ROUND_W(4)) sif ();

  rps_match_scorer #(
    .WIN_TARGET(WIN_TARGET), .MAX_ROUNDS(MAX_ROUNDS), .SCORE_W(3), .ROUND_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .sif  (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers following the match rules
  int  m_p1 = 0, m_p2 = 0, m_rounds = 0, m_inv = 0, m_last = 0, m_state = 0;
  bit  m_prev = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_last = 0; m_state = 0;
      m_prev = 0;
    end else if (ena) begin
      bit rose;
      rose   = sif.res_valid && !m_prev;
      m_prev = sif.res_valid;
      if (sif.new_match) begin
        m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_last = 0; m_state = 0;
      end else if (rose && m_state == 0) begin
        m_last = int'(sif.res_winner);
        if (m_last == 3) m_inv = (m_inv < 3) ? m_inv + 1 : 3;
        else begin
          m_rounds++;
          if (m_last == 1) m_p1++;
          if (m_last == 2) m_p2++;
        end
        if (m_p1 == WIN_TARGET)           m_state = 1;
        else if (m_p2 == WIN_TARGET)      m_state = 2;
        else if (m_rounds == MAX_ROUNDS)  m_state = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
      end
    end
  end

  // Every-cycle comparison away from the active edge
  always @(negedge clk) begin
    chk("p1_score",    int'(sif.p1_score),    m_p1);
    chk("p2_score",    int'(sif.p2_score),    m_p2);
    chk("round_cnt",   int'(sif.round_cnt),   m_rounds);
    chk("invalid_cnt", int'(sif.invalid_cnt), m_inv);
    chk("last_result", int'(sif.last_result), m_last);
    chk("match_state", int'(sif.match_state), m_state);
    chk("match_done",  int'(sif.match_done),  int'(m_state != 0));
  end

  // All tasks start and end at posedge+1
  task automatic pulse(input logic [1:0] w, input int hold);
    sif.res_valid  = 1'b1;
    sif.res_winner = w;
    repeat (hold) @(posedge clk);
    #1;
    sif.res_valid  = 1'b0;
    sif.res_winner = 2'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic clear_match();
    sif.new_match = 1'b1;
    @(posedge clk); #1;
    sif.new_match = 1'b0;
  endtask

  task automatic lit(input string tag, input int p1, input int p2, input int rc,
                     input int inv, input int lr, input int ms);
    chk({tag, ".p1"},    int'(sif.p1_score),    p1);
    chk({tag, ".p2"},    int'(sif.p2_score),    p2);
    chk({tag, ".round"}, int'(sif.round_cnt),   rc);
    chk({tag, ".inv"},   int'(sif.invalid_cnt), inv);
    chk({tag, ".last"},  int'(sif.last_result), lr);
    chk({tag, ".state"}, int'(sif.match_state), ms);
    chk({tag, ".done"},  int'(sif.match_done),  int'(ms != 0));
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    sif.res_valid = 1'b0;
    sif.res_winner = 2'b00;
    sif.new_match = 1'b0;
    #3;
    lit("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Held level counts once; check right after the first edge too
    sif.res_valid = 1'b1; sif.res_winner = 2'b01;
    @(posedge clk); #1;
    lit("first_edge", 1, 0, 1, 0, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    sif.res_valid = 1'b0;
    @(posedge clk); #1;
    lit("held5", 1, 0, 1, 0, 1, 0);

    // P1 reaches target; later rounds ignored
    clear_match();
    pulse(2'b01, 1); pulse(2'b10, 1); pulse(2'b01, 1); pulse(2'b10, 1);
    pulse(2'b01, 2);
    lit("p1_wins", 3, 2, 5, 0, 1, 1);
    pulse(2'b10, 1);
    lit("frozen", 3, 2, 5, 0, 1, 1);

    // Round limit with level scores
    clear_match();
    lit("cleared", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) pulse(2'b00, 1);
    pulse(2'b01, 1); pulse(2'b01, 1); pulse(2'b10, 1); pulse(2'b10, 1);
    lit("draw", 2, 2, 9, 0, 2, 3);

    // Round limit with a leader
    clear_match();
    for (int i = 0; i < 6; i++) pulse(2'b00, 1);
    pulse(2'b10, 1); pulse(2'b01, 1); pulse(2'b01, 1);
    lit("limit_lead", 2, 1, 9, 0, 1, 1);

    // Invalid rounds saturate and never score
    clear_match();
    for (int i = 0; i < 4; i++) pulse(2'b11, 1);
    lit("invalid", 0, 0, 0, 3, 3, 0);

    // Clear coincident with a rise at 2-2; held level not re-counted
    clear_match();
    pulse(2'b01, 1); pulse(2'b10, 1); pulse(2'b01, 1); pulse(2'b10, 1);
    lit("two_all", 2, 2, 4, 0, 2, 0);
    sif.new_match = 1'b1; sif.res_valid = 1'b1; sif.res_winner = 2'b10;
    @(posedge clk); #1;
    sif.new_match = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("clr_vs_rise", 0, 0, 0, 0, 0, 0);
    sif.res_valid = 1'b0;
    @(posedge clk); #1;

    // Enable low holds everything; rise seen when enable returns
    ena = 1'b0;
    sif.res_valid = 1'b1; sif.res_winner = 2'b01;
    sif.new_match = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("ena_low", 0, 0, 0, 0, 0, 0);
    sif.new_match = 1'b0;
    ena = 1'b1;
    @(posedge clk); #1;
    lit("ena_back", 1, 0, 1, 0, 1, 0);
    sif.res_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle at 2-1
    clear_match();
    pulse(2'b01, 1); pulse(2'b10, 1); pulse(2'b01, 1);
    lit("pre_rst", 2, 1, 3, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pulse(2'b10, 1);
    lit("after_rst", 0, 1, 1, 0, 2, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
